// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle sequencing FSM with flag register (optional MEM_WAIT_EN memory wait)
module multicycle_controller #(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter logic [3:0] PC_IDX   = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] reg_src,
  output logic [3:0] state_o,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

`ifndef MEM_WAIT_EN
  logic mem_ready;
  assign mem_ready = 1'b1;
`endif

  state_t     state;
  logic [3:0] flags;
  logic       cond_ex;
  logic [3:0] alu_dec;
  logic [3:0] cmd;
  logic       is_cmp;
  logic       wr_en;
  logic       pc_wb;
  logic       flag_we;

  assign cmd     = funct[4:1];
  assign is_cmp  = (cmd == 4'b1010);
  assign wr_en   = cond_ex & (rd != PC_IDX);
  assign pc_wb   = cond_ex & (rd == PC_IDX);
  assign flag_we = ((state == EXECR) || (state == EXECI)) & cond_ex & (funct[0] | is_cmp);

  // Evaluate the condition field against the stored NZCV flags
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      default: cond_ex = 1'b1;
    endcase
  end

  // Map the data-processing cmd field onto the ALU operation code
  always_comb begin
    alu_dec = ALU_ADD;
    case (cmd)
      4'b0100: alu_dec = ALU_ADD;
      4'b0010: alu_dec = ALU_SUB;
      4'b1010: alu_dec = ALU_SUB;
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      4'b0001: alu_dec = ALU_EOR;
      4'b1101: alu_dec = ALU_MOV;
      default: alu_dec = ALU_ADD;
    endcase
  end

  // State sequencing and flag capture at the end of the execute step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      flags <= FLAG_RST;
    end else begin
      case (state)
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            2'b00:   state <= funct[5] ? EXECI : EXECR;
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR: state <= funct[0] ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (mem_ready) state <= FETCH;
        EXECR, EXECI: begin
          state <= ALUWB;
          if (flag_we) flags <= alu_flags;
        end
        ALUWB:  state <= FETCH;
        BRANCH: state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Per-state datapath controls; everything held at zero while in reset
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_src     = 2'b00;
    state_o     = 4'd0;
    instr_done  = 1'b0;
    if (!rst) begin
      state_o = state;
      reg_src = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
      case (state)
        FETCH: begin
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
        DECODE: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          instr_done = (op == 2'b11);
        end
        MEMADR: alu_src_b = 2'b01;
        MEMRD:  adr_src = 1'b1;
        MEMWB: begin
          result_src = 2'b01;
          reg_write  = wr_en;
          pc_write   = pc_wb;
          instr_done = 1'b1;
        end
        MEMWR: begin
          adr_src    = 1'b1;
          mem_write  = cond_ex;
          instr_done = mem_ready;
        end
        EXECR: alu_control = alu_dec;
        EXECI: begin
          alu_src_b   = 2'b01;
          alu_control = alu_dec;
        end
        ALUWB: begin
          reg_write  = wr_en & ~is_cmp;
          pc_write   = pc_wb;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = cond_ex;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM that drives the shared datapath in multicycle mode: one ALU, one unified memory, an instruction register (IR) and non-architectural ALUOut/Data registers.
- Decodes cond/op/funct/rd from the IR, holds the NZCV flag register, evaluates condition codes, and emits per-cycle mux selects and write strobes.
- Sits beside the datapath in the top level.

Parameters:
- FLAG_RST, 4'b0000, reset value of the NZCV flag register ({N,Z,C,V}).
- PC_IDX, 4'd15, register index treated as the PC for writeback redirection.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cond  input  4  IR[31:28].
- op  input  2  IR[27:26].
- funct  input  6  IR[25:20]; bit5 = I, bits4:1 = cmd, bit0 = S (DP) or L (memory).
- rd  input  4  IR[15:12].
- alu_flags  input  4  live ALU {N,Z,C,V}.
- pc_write  output  1  PC load strobe.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  IR load strobe.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register file write strobe.
- result_src  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU direct.
- alu_src_a  output  1  ALU A select: 0 = Rn, 1 = PC.
- alu_src_b  output  2  ALU B select: 00 = Rm, 01 = extended immediate, 10 = constant 4.
- alu_control  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (pass B).
- reg_src  output  2  bit0 = (op==10), bit1 = (op==01 & ~funct[0]); combinational in all states.
- state_o  output  4  current state encoding.
- instr_done  output  1  high in the last cycle of each instruction.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is synchronous and active-high (rst).
  - With rst=1 at a clock edge: state <= FETCH (0), flags <= FLAG_RST.
  - While rst=1: pc_write, ir_write, mem_write, reg_write and instr_done are forced 0; all selects are 0; state_o = 0.
  - Reset asserted mid-instruction aborts it; no partial write occurs in the cycle rst is high.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 are illegal and return to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: op=00 and I=0 -> EXECR; op=00 and I=1 -> EXECI; op=01 -> MEMADR; op=10 -> BRANCH; op=11 (undefined) -> FETCH with instr_done=1.
  - MEMADR -> MEMRD if L=1, else MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR/EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Instruction latency: branch 3, store 4, DP 4, load 5 cycles.
- Outputs are a pure function of state, IR fields and flags. Unlisted outputs are 0.
  - FETCH: ir_write=1, pc_write=1, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - DECODE: alu_src_a=1, alu_src_b=10, ADD (forms PC+8).
  - MEMADR: alu_src_b=01, ADD.
  - MEMRD: adr_src=1.
  - MEMWB: result_src=01, reg_write=wr_en.
  - MEMWR: adr_src=1, mem_write=cond_ex.
  - EXECR: alu_src_b=00, decoded ALU op.
  - EXECI: alu_src_b=01, decoded ALU op.
  - ALUWB: result_src=00, reg_write=wr_en & (cmd!=CMP).
  - BRANCH: alu_src_b=01, ADD, result_src=10, pc_write=cond_ex.
- Writeback redirection: in MEMWB/ALUWB with rd==PC_IDX, pc_write=cond_ex and reg_write=0. wr_en = cond_ex & (rd!=PC_IDX).
- cmd decode:
  - 0100 -> ADD; 0010 -> SUB; 1010 (CMP) -> SUB with no writeback.
  - 0000 -> AND; 1100 -> ORR; 0001 -> EOR; 1101 -> MOV.
  - Any other cmd -> ADD.
- Condition codes (cond_ex):
  - EQ 0000: Z; NE 0001: ~Z; CS 0010: C; CC 0011: ~C.
  - MI 0100: N; PL 0101: ~N; VS 0110: V; VC 0111: ~V.
  - HI 1000: C&~Z; LS 1001: ~C|Z; GE 1010: N==V; LT 1011: N!=V.
  - GT 1100: ~Z&(N==V); LE 1101: Z|(N!=V); 1110 and 1111: 1.
- Flags register:
  - Latches alu_flags at the end of EXECR/EXECI when S=1 and cond_ex=1, or when cmd=CMP and cond_ex=1.
  - Unchanged otherwise, including on memory and branch instructions.
- instr_done is high in MEMWB, MEMWR, ALUWB and BRANCH, and in DECODE for op=11.

Optional Feature:
- Macro: MEM_WAIT_EN.
- When defined:
  - Adds input port mem_ready (1 bit), listed after alu_flags.
  - FETCH, MEMRD and MEMWR hold their state while mem_ready=0.
  - In FETCH, ir_write and pc_write are asserted only in the cycle with mem_ready=1.
  - In MEMWR, mem_write stays high (if cond_ex) through the wait; instr_done is asserted only in the cycle with mem_ready=1.
- When undefined: no mem_ready port; behaviour equals mem_ready tied to 1.

Test Plan:
- Reset: rst=1 for 2 cycles in state EXECR -> state_o=0, all strobes 0, flags=0000. Release -> FETCH cycle with ir_write=1, pc_write=1, alu_control=0000.
- ADD imm: op=00, funct=101000, cond=1110, rd=3 -> states 0,1,7,8. EXECI: alu_src_b=01, alu_control=0000. ALUWB: reg_write=1, result_src=00, instr_done=1.
- CMP then BEQ:
  - CMP (funct=010101) with alu_flags=0100 -> flags=0100, no reg_write.
  - Branch cond=0000 -> states 0,1,9; BRANCH pc_write=1.
  - Repeat with flags=0000 -> BRANCH pc_write=0.
- Load rd=15: op=01, funct=011001 -> states 0,1,2,3,4. MEMRD adr_src=1. MEMWB pc_write=1, reg_write=0, result_src=01.
- Store with failed cond=0001 while Z=1 -> states 0,1,2,5; mem_write=0; reg_src=10; instr_done=1 in MEMWR.
- MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH -> state_o stays 0 with ir_write=0 and pc_write=0; the cycle mem_ready=1 gives ir_write=1, then DECODE.
